// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/ONESHOT mode with a run-time
// half-period, one-cycle config writes, and a global sync that re-phases BLINK channels.
module led_pattern_ctrl #(
    parameter int CH_NUM   = 4,
    parameter int CNT_W    = 26,
    parameter int DEF_HALF = 24_999_999,
    localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic              sync,
    output logic [CH_NUM-1:0] led_out,
    output logic [CH_NUM-1:0] tick_out
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] DEF_HALF_C = CNT_W'(DEF_HALF);

    mode_e            mode_q [CH_NUM];
    mode_e            mode_d [CH_NUM];
    logic [CNT_W-1:0] half_q [CH_NUM];
    logic [CNT_W-1:0] half_d [CH_NUM];
    logic [CNT_W-1:0] cnt_q  [CH_NUM];
    logic [CNT_W-1:0] cnt_d  [CH_NUM];
    logic [CH_NUM-1:0] led_q, led_d;
    logic [CH_NUM-1:0] tick_q, tick_d;

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            // NOTE: every next-state signal gets its hold value first so no path infers a latch.
            mode_d[i] = mode_q[i];
            half_d[i] = half_q[i];
            cnt_d[i]  = cnt_q[i];
            led_d[i]  = led_q[i];
            tick_d[i] = 1'b0;

            // Out-of-range channel numbers never match any i, so such writes are dropped.
            if (cfg_we && (32'(cfg_ch) == i)) begin
                mode_d[i] = mode_e'(cfg_mode);
                half_d[i] = cfg_half;
                cnt_d[i]  = '0;
                led_d[i]  = (mode_e'(cfg_mode) != MODE_OFF);
            end else if (sync && (mode_q[i] == MODE_BLINK)) begin
                cnt_d[i] = '0;
                led_d[i] = 1'b1;
            end else begin
                unique case (mode_q[i])
                    MODE_OFF: begin
                        cnt_d[i] = '0;
                        led_d[i] = 1'b0;
                    end
                    MODE_ON: begin
                        cnt_d[i] = '0;
                        led_d[i] = 1'b1;
                    end
                    MODE_BLINK: begin
                        if (cnt_q[i] == half_q[i]) begin
                            cnt_d[i]  = '0;
                            led_d[i]  = ~led_q[i];
                            tick_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (cnt_q[i] == half_q[i]) begin
                            cnt_d[i]  = '0;
                            led_d[i]  = 1'b0;
                            tick_d[i] = 1'b1;
                            mode_d[i] = MODE_OFF;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                            led_d[i] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the per-channel arrays are real state registers, so they are reset like any flop.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < CH_NUM; i++) begin
                mode_q[i] <= MODE_BLINK;
                half_q[i] <= DEF_HALF_C;
                cnt_q[i]  <= '0;
            end
            led_q  <= '0;
            tick_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            mode_q <= mode_d;
            half_q <= half_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    assign led_out  = led_q;
    assign tick_out = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl: a 4-channel and a 3-channel instance, CNT_W=8,
// DEF_HALF=9; every expected waveform is derived here from cycle counts.
module tb_led_pattern_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_half = '0;
    logic       sync = 1'b0;
    logic [3:0] led_out, tick_out;

    logic       cfg_we3 = 1'b0;
    logic [1:0] cfg_ch3 = '0;
    logic [1:0] cfg_mode3 = '0;
    logic [7:0] cfg_half3 = '0;
    logic [2:0] led3, tick3;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    always #5 sys_clk = ~sys_clk;

    led_pattern_ctrl #(.CH_NUM(4), .CNT_W(8), .DEF_HALF(9)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_half(cfg_half),
        .sync    (sync),
        .led_out (led_out),
        .tick_out(tick_out)
    );

    led_pattern_ctrl #(.CH_NUM(3), .CNT_W(8), .DEF_HALF(9)) dut3 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .cfg_we  (cfg_we3),
        .cfg_ch  (cfg_ch3),
        .cfg_mode(cfg_mode3),
        .cfg_half(cfg_half3),
        .sync    (1'b0),
        .led_out (led3),
        .tick_out(tick3)
    );

    task automatic tick_clk();
        @(posedge sys_clk);
        #1;
        edge_cnt++;
    endtask

    task automatic test_reset();
        logic e, t;
        sys_rst = 1'b1;
        tick_clk();
        tick_clk();
        n_checks++;
        if (led_out !== 4'b0000 || tick_out !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_state: led=%b tick=%b required led=0000 tick=0000", led_out, tick_out);
        end
        n_checks++;
        if (led3 !== 3'b000 || tick3 !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_state3: led=%b tick=%b required 000/000", led3, tick3);
        end
        sys_rst = 1'b0;
        edge_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            tick_clk();
            e = ((k / 10) % 2) == 1;
            t = (k % 10) == 0;
            n_checks++;
            if (led_out !== {4{e}} || tick_out !== {4{t}}) begin
                n_errors++;
                $display("FAIL default_blink k=%0d: led=%b tick=%b required led=%b tick=%b",
                         k, led_out, tick_out, {4{e}}, {4{t}});
            end
        end
    endtask

    task automatic test_config();
        logic e, t;
        for (int j = 0; j < 30; j++) begin
            cfg_we   = (j < 3);
            cfg_ch   = 2'(j + 1);
            cfg_mode = (j == 0) ? 2'b10 : (j == 1) ? 2'b01 : 2'b00;
            cfg_half = 8'd2;
            tick_clk();
            e = ((j / 3) % 2) == 0;
            t = (j > 0) && (j % 3 == 0);
            n_checks++;
            if (led_out[1] !== e || tick_out[1] !== t) begin
                n_errors++;
                $display("FAIL ch1_blink j=%0d: led=%b tick=%b required led=%b tick=%b",
                         j, led_out[1], tick_out[1], e, t);
            end
            if (j >= 1) begin
                n_checks++;
                if (led_out[2] !== 1'b1 || tick_out[2] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL ch2_on j=%0d: led=%b tick=%b required 1/0", j, led_out[2], tick_out[2]);
                end
            end
            if (j >= 2) begin
                n_checks++;
                if (led_out[3] !== 1'b0 || tick_out[3] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL ch3_off j=%0d: led=%b tick=%b required 0/0", j, led_out[3], tick_out[3]);
                end
            end
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_oneshot();
        logic e, t;
        // Pass 0: single pulse of 5 cycles; pass 1: rewrite after 2 cycles gives 7.
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < 16; j++) begin
                cfg_we   = (j == 0) || (pass == 1 && j == 2);
                cfg_ch   = 2'd0;
                cfg_mode = 2'b11;
                cfg_half = 8'd4;
                tick_clk();
                e = (pass == 0) ? (j < 5) : (j < 7);
                t = (pass == 0) ? (j == 5) : (j == 7);
                n_checks++;
                if (led_out[0] !== e || tick_out[0] !== t) begin
                    n_errors++;
                    $display("FAIL oneshot pass=%0d j=%0d: led=%b tick=%b required led=%b tick=%b",
                             pass, j, led_out[0], tick_out[0], e, t);
                end
            end
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_sync();
        logic e, t;
        for (int j = 0; j < 7; j++) begin
            cfg_we   = (j == 0) || (j == 2);
            cfg_ch   = (j == 0) ? 2'd0 : 2'd1;
            cfg_mode = 2'b10;
            cfg_half = 8'd3;
            tick_clk();
        end
        cfg_we = 1'b0;
        for (int m = 0; m < 120; m++) begin
            sync = (m == 0);
            tick_clk();
            e = ((m / 4) % 2) == 0;
            t = (m > 0) && (m % 4 == 0);
            n_checks++;
            if (led_out !== {2'b01, e, e} || tick_out !== {2'b00, t, t}) begin
                n_errors++;
                $display("FAIL sync_align m=%0d: led=%b tick=%b required led=%b tick=%b",
                         m, led_out, tick_out, {2'b01, e, e}, {2'b00, t, t});
            end
        end
        sync = 1'b0;
    endtask

    task automatic test_sync_and_write();
        logic e, t;
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mode = 2'b10; cfg_half = 8'd5;
        tick_clk();
        cfg_we = 1'b0;
        tick_clk();
        tick_clk();
        tick_clk();
        for (int m = 0; m < 13; m++) begin
            cfg_we   = (m == 0);
            sync     = (m == 0);
            cfg_ch   = 2'd2;
            cfg_mode = 2'b11;
            cfg_half = 8'd1;
            tick_clk();
            e = ((m / 4) % 2) == 0;
            t = (m > 0) && (m % 4 == 0);
            n_checks++;
            if (led_out !== {1'b0, (m < 2), e, e} || tick_out !== {1'b0, (m == 2), t, t}) begin
                n_errors++;
                $display("FAIL sync_write m=%0d: led=%b tick=%b required led=%b tick=%b",
                         m, led_out, tick_out, {1'b0, (m < 2), e, e}, {1'b0, (m == 2), t, t});
            end
        end
        cfg_we = 1'b0;
        sync   = 1'b0;
    endtask

    task automatic test_invalid_ch();
        logic e, t;
        // dut3 has never been written, so it still follows the default pattern.
        for (int j = 0; j < 25; j++) begin
            cfg_we3   = (j < 2);
            cfg_ch3   = 2'd3;
            cfg_mode3 = (j == 0) ? 2'b00 : 2'b01;
            cfg_half3 = 8'd0;
            tick_clk();
            e = ((edge_cnt / 10) % 2) == 1;
            t = (edge_cnt % 10) == 0;
            n_checks++;
            if (led3 !== {3{e}} || tick3 !== {3{t}}) begin
                n_errors++;
                $display("FAIL invalid_ch j=%0d: led=%b tick=%b required led=%b tick=%b",
                         j, led3, tick3, {3{e}}, {3{t}});
            end
        end
        cfg_we3 = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic e, t;
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mode = 2'b11; cfg_half = 8'd20;
        tick_clk();
        cfg_we = 1'b0;
        tick_clk();
        tick_clk();
        tick_clk();
        sys_rst = 1'b1;
        tick_clk();
        sys_rst = 1'b0;
        n_checks++;
        if (led_out !== 4'b0000 || tick_out !== 4'b0000 || led3 !== 3'b000 || tick3 !== 3'b000) begin
            n_errors++;
            $display("FAIL mid_reset: led=%b tick=%b led3=%b tick3=%b required all zero",
                     led_out, tick_out, led3, tick3);
        end
        edge_cnt = 0;
        for (int k = 1; k <= 25; k++) begin
            tick_clk();
            e = ((k / 10) % 2) == 1;
            t = (k % 10) == 0;
            n_checks++;
            if (led_out !== {4{e}} || tick_out !== {4{t}} || led3 !== {3{e}} || tick3 !== {3{t}}) begin
                n_errors++;
                $display("FAIL post_reset k=%0d: led=%b tick=%b led3=%b tick3=%b required led=%b tick=%b",
                         k, led_out, tick_out, led3, tick3, e, t);
            end
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_oneshot();
        test_sync();
        test_sync_and_write();
        test_invalid_ch();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
